// File: rtl/proc_sequencer.sv
// proc_sequencer: holds a small program buffer and feeds it to an external
// processor one instruction at a time, waiting for the processor's Done flag
// between issues.
//
// Ports:
//   Clock, Reset       - sole clock; synchronous active-high reset
//   LoadEn/Addr/Data   - program buffer write port (ignored while Busy)
//   Start, Abort       - begin execution at PC=0 / return to IDLE (Abort wins)
//   ProcDone           - processor Done level; a rising edge completes an issue
//   ProcInstr, ProcRun - instruction word and one-cycle issue strobe
//   Busy/Halted/Fault  - status: executing / hit opcode 0 or end / WAIT timeout
//   PC, IssueCount     - program counter, completed instructions since Start
//
// Sized for DEPTH <= 16 (LoadAddr and PC are 4 bits wide).
module proc_sequencer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        LoadEn,
    input  logic [3:0]  LoadAddr,
    input  logic [15:0] LoadData,
    input  logic        Start,
    input  logic        Abort,
    input  logic        ProcDone,
    output logic [15:0] ProcInstr,
    output logic        ProcRun,
    output logic        Busy,
    output logic        Halted,
    output logic        Fault,
    output logic [3:0]  PC,
    output logic [7:0]  IssueCount
);

    localparam int unsigned PcW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TmW = $clog2(TIMEOUT + 1);
    localparam logic [PcW-1:0] PcLast = PcW'(DEPTH - 1);
    localparam logic [TmW-1:0] TmMax  = TmW'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle, StIssue, StWait, StAdvance, StHalt, StFault
    } state_e;

    state_e         state_q, state_d;
    logic [PcW-1:0] pc_q, pc_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [TmW-1:0] timer_q, timer_d;
    logic           done_prev_q, done_prev_d;
    logic [15:0]    buf_q [DEPTH];

    logic [15:0]    cur_instr;
    logic           done_rise;
    logic           buf_we;
    logic [PcW-1:0] buf_waddr;

    assign cur_instr = buf_q[pc_q];
    assign done_rise = ProcDone & ~done_prev_q;
    assign buf_waddr = PcW'(LoadAddr);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        done_prev_d = ProcDone;  // sampled every cycle so a stale high level never counts
        ProcRun     = 1'b0;

        case (state_q)
            StIdle, StHalt, StFault: begin
                if (Start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (cur_instr[15:12] == 4'h0) begin
                    state_d = StHalt;
                end else begin
                    ProcRun = 1'b1;
                    timer_d = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (done_rise) begin
                    state_d = StAdvance;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_q + 1'b1 == TmMax) begin
                        state_d = StFault;
                    end
                end
            end
            StAdvance: begin
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (pc_q == PcLast) begin
                    state_d = StHalt;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything decided above, including the issue strobe.
        if (Abort) begin
            state_d = StIdle;
            pc_d    = pc_q;
            cnt_d   = cnt_q;
            timer_d = timer_q;
            ProcRun = 1'b0;
        end
    end

    assign Busy   = (state_q == StIssue) || (state_q == StWait) || (state_q == StAdvance);
    assign Halted = (state_q == StHalt);
    assign Fault  = (state_q == StFault);
    assign buf_we = LoadEn && !Busy && (32'(LoadAddr) < DEPTH);

    assign ProcInstr  = ((state_q == StIssue) || (state_q == StWait)) ? cur_instr : 16'h0000;
    assign PC         = 4'(pc_q);
    assign IssueCount = cnt_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            done_prev_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            done_prev_q <= done_prev_d;
            if (buf_we) begin
                buf_q[buf_waddr] <= LoadData;
            end
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer. Inputs change and outputs are sampled on
// the falling clock edge; a small processor model raises Done a fixed number
// of cycles after each Run strobe.
module tb_proc_sequencer;

    logic        Clock = 1'b0;
    logic        Reset, LoadEn, Start, Abort, ProcDone;
    logic [3:0]  LoadAddr;
    logic [15:0] LoadData;
    logic [15:0] ProcInstr;
    logic        ProcRun, Busy, Halted, Fault;
    logic [3:0]  PC;
    logic [7:0]  IssueCount;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] seen [32];
    int          runs;
    logic        wrapped;
    logic        timed_out;

    proc_sequencer #(.DEPTH(16), .TIMEOUT(15)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .LoadEn     (LoadEn),
        .LoadAddr   (LoadAddr),
        .LoadData   (LoadData),
        .Start      (Start),
        .Abort      (Abort),
        .ProcDone   (ProcDone),
        .ProcInstr  (ProcInstr),
        .ProcRun    (ProcRun),
        .Busy       (Busy),
        .Halted     (Halted),
        .Fault      (Fault),
        .PC         (PC),
        .IssueCount (IssueCount)
    );

    always #5 Clock = ~Clock;

    task automatic cyc();
        @(negedge Clock);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        LoadEn   = 1'b1;
        LoadAddr = a;
        LoadData = d;
        cyc();
        LoadEn   = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
    endtask

    // Processor model: Done falls on Run, rises `delay` cycles after Run.
    task automatic run_model(input int delay, input int max_cyc);
        int cnt;
        logic [3:0] prev_pc;
        cnt     = 0;
        runs    = 0;
        wrapped = 1'b0;
        prev_pc = PC;
        for (int i = 0; i < max_cyc; i++) begin
            if (Halted || Fault) break;
            if (PC < prev_pc) wrapped = 1'b1;
            prev_pc = PC;
            if (ProcRun) begin
                if (runs < 32) seen[runs] = ProcInstr;
                runs++;
                ProcDone = 1'b0;
                cnt = delay;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) ProcDone = 1'b1;
            end
            cyc();
        end
        timed_out = !(Halted || Fault);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ProcRun, Busy, Halted, Fault, PC, IssueCount, ProcInstr} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {ProcRun, Busy, Halted, Fault, PC, IssueCount, ProcInstr});
        end
    endtask

    task automatic test_program();
        do_reset();
        load(4'd0, 16'h5312);
        load(4'd1, 16'h6134);
        load(4'd2, 16'h0000);
        pulse_start();
        run_model(4, 60);
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL prog_done: no halt within bound"); end
        n_cmp++; if (runs != 2) begin n_err++; $display("FAIL prog_runs: got %0d expected 2", runs); end
        n_cmp++; if (seen[0] !== 16'h5312) begin n_err++; $display("FAIL prog_instr0: got %h expected 5312", seen[0]); end
        n_cmp++; if (seen[1] !== 16'h6134) begin n_err++; $display("FAIL prog_instr1: got %h expected 6134", seen[1]); end
        n_cmp++; if ({Halted, Busy, Fault} !== 3'b100) begin n_err++; $display("FAIL prog_halt: got %b expected 100", {Halted, Busy, Fault}); end
        n_cmp++; if (PC !== 4'd2) begin n_err++; $display("FAIL prog_pc: got %0d expected 2", PC); end
        n_cmp++; if (IssueCount !== 8'd2) begin n_err++; $display("FAIL prog_count: got %0d expected 2", IssueCount); end
        n_cmp++; if (ProcInstr !== 16'h0) begin n_err++; $display("FAIL prog_instr_halt: got %h expected 0", ProcInstr); end
        // Restart from HALT
        pulse_start();
        n_cmp++;
        if ({ProcRun, Busy, PC, IssueCount, ProcInstr} !== {1'b1, 1'b1, 4'd0, 8'd0, 16'h5312}) begin
            n_err++;
            $display("FAIL restart: got %h expected %h", {ProcRun, Busy, PC, IssueCount, ProcInstr},
                     {1'b1, 1'b1, 4'd0, 8'd0, 16'h5312});
        end
        Abort = 1'b1;
        cyc();
        Abort = 1'b0;
        n_cmp++; if ({Busy, ProcRun, Halted} !== 3'b000) begin n_err++; $display("FAIL abort_issue: got %b expected 000", {Busy, ProcRun, Halted}); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) load(4'(i), 16'h4010);
        pulse_start();
        run_model(4, 200);
        n_cmp++; if (runs != 16) begin n_err++; $display("FAIL full_runs: got %0d expected 16", runs); end
        n_cmp++; if (Halted !== 1'b1) begin n_err++; $display("FAIL full_halt: got %b expected 1", Halted); end
        n_cmp++; if (PC !== 4'd15) begin n_err++; $display("FAIL full_pc: got %0d expected 15", PC); end
        n_cmp++; if (IssueCount !== 8'd16) begin n_err++; $display("FAIL full_count: got %0d expected 16", IssueCount); end
        n_cmp++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL full_wrap: got %b expected 0", wrapped); end
    endtask

    task automatic test_timeout();
        int waits;
        int nrun;
        do_reset();
        load(4'd0, 16'h4010);
        ProcDone = 1'b0;
        pulse_start();
        waits = 0;
        nrun  = 0;
        for (int i = 0; i < 40; i++) begin
            if (Fault) break;
            if (ProcRun) nrun++;
            else if (Busy) waits++;
            cyc();
        end
        n_cmp++; if (Fault !== 1'b1) begin n_err++; $display("FAIL to_fault: got %b expected 1", Fault); end
        n_cmp++; if (waits != 15) begin n_err++; $display("FAIL to_waits: got %0d expected 15", waits); end
        n_cmp++; if (nrun != 1) begin n_err++; $display("FAIL to_runs: got %0d expected 1", nrun); end
        n_cmp++;
        if ({Busy, Halted, PC, IssueCount, ProcInstr} !== 30'h0) begin
            n_err++;
            $display("FAIL to_state: got %h expected 0", {Busy, Halted, PC, IssueCount, ProcInstr});
        end
        Abort = 1'b1;
        cyc();
        Abort = 1'b0;
        n_cmp++; if (Fault !== 1'b0) begin n_err++; $display("FAIL to_abort: got %b expected 0", Fault); end
    endtask

    task automatic test_abort();
        int   cnt;
        int   nrun;
        logic found;
        do_reset();
        load(4'd0, 16'h4010);
        load(4'd1, 16'h5312);
        load(4'd2, 16'h0000);
        ProcDone = 1'b0;
        pulse_start();
        cnt   = 0;
        nrun  = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (nrun == 2 && Busy && !ProcRun) begin found = 1'b1; break; end
            if (ProcRun) begin nrun++; ProcDone = 1'b0; cnt = 4; end
            else if (cnt > 0) begin cnt--; if (cnt == 0) ProcDone = 1'b1; end
            cyc();
        end
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL ab_reach_wait: got %b expected 1", found); end
        // Write and Start while busy must both be dropped.
        LoadEn = 1'b1; LoadAddr = 4'd1; LoadData = 16'hABCD; Start = 1'b1;
        cyc();
        LoadEn = 1'b0; Start = 1'b0;
        n_cmp++;
        if ({Busy, PC, ProcInstr} !== {1'b1, 4'd1, 16'h5312}) begin
            n_err++;
            $display("FAIL ab_wait_hold: got %h expected %h", {Busy, PC, ProcInstr}, {1'b1, 4'd1, 16'h5312});
        end
        Abort = 1'b1;
        cyc();
        Abort = 1'b0;
        n_cmp++;
        if ({Busy, Halted, Fault, ProcRun, PC, IssueCount, ProcInstr} !== {4'b0000, 4'd1, 8'd1, 16'h0}) begin
            n_err++;
            $display("FAIL ab_idle: got %h expected %h", {Busy, Halted, Fault, ProcRun, PC, IssueCount, ProcInstr},
                     {4'b0000, 4'd1, 8'd1, 16'h0});
        end
        ProcDone = 1'b0;
        pulse_start();
        run_model(4, 60);
        n_cmp++; if (runs != 2) begin n_err++; $display("FAIL ab_rerun_runs: got %0d expected 2", runs); end
        n_cmp++; if (seen[1] !== 16'h5312) begin n_err++; $display("FAIL ab_buf_kept: got %h expected 5312", seen[1]); end
    endtask

    task automatic test_done_held();
        do_reset();
        load(4'd0, 16'h4010);
        load(4'd1, 16'h4020);
        load(4'd2, 16'h0000);
        ProcDone = 1'b1;
        cyc();
        pulse_start();
        repeat (5) cyc();
        n_cmp++;
        if ({Busy, PC, IssueCount, ProcInstr} !== {1'b1, 4'd0, 8'd0, 16'h4010}) begin
            n_err++;
            $display("FAIL dh_stale0: got %h expected %h", {Busy, PC, IssueCount, ProcInstr}, {1'b1, 4'd0, 8'd0, 16'h4010});
        end
        ProcDone = 1'b0;
        cyc();
        ProcDone = 1'b1;
        cyc();
        n_cmp++;
        if ({Busy, ProcRun, ProcInstr} !== {1'b1, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL dh_advance: got %h expected %h", {Busy, ProcRun, ProcInstr}, {1'b1, 1'b0, 16'h0});
        end
        cyc();
        n_cmp++;
        if ({ProcRun, PC, IssueCount, ProcInstr} !== {1'b1, 4'd1, 8'd1, 16'h4020}) begin
            n_err++;
            $display("FAIL dh_issue1: got %h expected %h", {ProcRun, PC, IssueCount, ProcInstr}, {1'b1, 4'd1, 8'd1, 16'h4020});
        end
        repeat (4) cyc();
        n_cmp++;
        if ({Busy, ProcRun, PC, IssueCount} !== {1'b1, 1'b0, 4'd1, 8'd1}) begin
            n_err++;
            $display("FAIL dh_stale1: got %h expected %h", {Busy, ProcRun, PC, IssueCount}, {1'b1, 1'b0, 4'd1, 8'd1});
        end
        Abort = 1'b1;
        cyc();
        Abort = 1'b0;
        ProcDone = 1'b0;
    endtask

    task automatic test_start_abort_reset();
        int nrun;
        do_reset();
        Start = 1'b1; Abort = 1'b1;
        cyc();
        Start = 1'b0; Abort = 1'b0;
        n_cmp++; if ({Busy, ProcRun} !== 2'b00) begin n_err++; $display("FAIL sa_idle: got %b expected 00", {Busy, ProcRun}); end
        load(4'd0, 16'h4010);
        pulse_start();
        n_cmp++; if (ProcRun !== 1'b1) begin n_err++; $display("FAIL rst_pre_issue: got %b expected 1", ProcRun); end
        Reset = 1'b1; Start = 1'b1; LoadEn = 1'b1; LoadAddr = 4'd0; LoadData = 16'h7777;
        cyc();
        Reset = 1'b0; Start = 1'b0; LoadEn = 1'b0;
        n_cmp++;
        if ({ProcRun, Busy, Halted, Fault, PC, IssueCount, ProcInstr} !== 32'h0) begin
            n_err++;
            $display("FAIL rst_issue_outputs: got %h expected 0", {ProcRun, Busy, Halted, Fault, PC, IssueCount, ProcInstr});
        end
        pulse_start();
        n_cmp++; if ({ProcRun, ProcInstr} !== 17'h0) begin n_err++; $display("FAIL rst_buf_cleared: got %h expected 0", {ProcRun, ProcInstr}); end
        cyc();
        n_cmp++; if (Halted !== 1'b1) begin n_err++; $display("FAIL rst_buf_halt: got %b expected 1", Halted); end
        // Reset mid-WAIT abandons the instruction.
        load(4'd0, 16'h4010);
        pulse_start();
        cyc();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        nrun = 0;
        repeat (4) begin
            if (ProcRun) nrun++;
            cyc();
        end
        n_cmp++; if (nrun != 0) begin n_err++; $display("FAIL rst_wait_norun: got %0d expected 0", nrun); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rst_wait_busy: got %b expected 0", Busy); end
    endtask

    initial begin
        Reset = 1'b1; LoadEn = 1'b0; LoadAddr = 4'd0; LoadData = 16'h0;
        Start = 1'b0; Abort = 1'b0; ProcDone = 1'b0;
        cyc();
        cyc();
        Reset = 1'b0;
        test_reset();
        test_program();
        test_full();
        test_timeout();
        test_abort();
        test_done_held();
        test_start_abort_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
